// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared types and widths for the ALU command sequencer.
//             Holds the opcode and FSM state enums, the command record
//             stored in the FIFO, and the datapath width constants.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 16;
    localparam int OP_W   = 3;
    localparam int TAG_W  = 8;

    typedef enum logic [OP_W-1:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        AND = 3'd4,
        WR  = 3'd5,
        RD  = 3'd6
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ARM   = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } seq_state_e;

    // One queued command as stored in the FIFO.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_fifo
//  Purpose  : Single-clock synchronous FIFO. Pointers wrap modulo DEPTH
//             (power of two); occupancy uses one extra bit so full and
//             empty are never ambiguous. Head data is read combinationally.
//  Ports    : clk, reset_n (async, active-low)
//             push_i/data_i  - write side (ignored when full)
//             pop_i/data_o   - read side (ignored when empty)
//             full_o/empty_o - registered-occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i  && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule : alu_seq_fifo
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Purpose  : Queues ALU commands, issues them one at a time with a start
//             pulse, waits for completion and presents a tagged response.
//             FSM: IDLE -> ISSUE -> ARM -> WAIT -> RESP -> IDLE.
//  Ports    : clk, reset_n (async, active-low)
//             cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op      - command input
//             alu_a/alu_b/alu_op/alu_start/alu_done/alu_result - ALU side
//             rsp_valid/rsp_ready/rsp_result/rsp_op/rsp_tag/rsp_error
//  Config   : ALU_CMD_SEQUENCER_TIMEOUT_EN - abort WAIT after TIMEOUT cycles
//             with rsp_error=1; undefined: WAIT is unbounded, rsp_error=0.
//  Revision : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [RES_W-1:0]  alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic [OP_W-1:0]   rsp_op,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_error
);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TAG_W-1:0]  issue_tag_q, issue_tag_d;
    logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
    logic [OP_W-1:0]   rsp_op_q, rsp_op_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              ready_en_q;

    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    cmd_t fifo_in;
    cmd_t fifo_head;

`ifdef ALU_CMD_SEQUENCER_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             rsp_error_q, rsp_error_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

    // ready_en_q holds cmd_ready low throughout reset and for the first
    // clock after release, keeping cmd_ready a function of registers only.
    assign cmd_ready = ready_en_q && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_in   = '{op: cmd_op, a: cmd_a, b: cmd_b};

    alu_seq_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        fifo_pop     = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        tag_d        = tag_q;
        issue_tag_d  = issue_tag_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_tag_d    = rsp_tag_q;
`ifdef ALU_CMD_SEQUENCER_TIMEOUT_EN
        timer_d      = timer_q;
        rsp_error_d  = rsp_error_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty && alu_done) begin
                    state_d     = ISSUE;
                    fifo_pop    = 1'b1;
                    alu_a_d     = fifo_head.a;
                    alu_b_d     = fifo_head.b;
                    alu_op_d    = fifo_head.op;
                    // The issued command keeps the current tag; the counter
                    // moves on for the next one and wraps naturally at 255.
                    issue_tag_d = tag_q;
                    tag_d       = tag_q + TAG_W'(1);
                end
            end
            ISSUE: state_d = ARM;
            ARM: begin
                // alu_done may still show the previous idle level here.
                state_d = WAIT;
`ifdef ALU_CMD_SEQUENCER_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            WAIT: begin
                if (alu_done) begin
                    state_d      = RESP;
                    rsp_result_d = alu_result;
                    rsp_op_d     = alu_op_q;
                    rsp_tag_d    = issue_tag_q;
`ifdef ALU_CMD_SEQUENCER_TIMEOUT_EN
                    rsp_error_d  = 1'b0;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d      = RESP;
                    rsp_result_d = '0;
                    rsp_op_d     = alu_op_q;
                    rsp_tag_d    = issue_tag_q;
                    rsp_error_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
`endif
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            tag_q        <= '0;
            issue_tag_q  <= '0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_tag_q    <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            tag_q        <= tag_d;
            issue_tag_q  <= issue_tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_tag_q    <= rsp_tag_d;
            ready_en_q   <= 1'b1;
        end
    end

`ifdef ALU_CMD_SEQUENCER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q     <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            rsp_error_q <= rsp_error_d;
        end
    end
    assign rsp_error = rsp_error_q;
`else
    assign rsp_error = 1'b0;
`endif

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_start  = (state_q == ISSUE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_tag    = rsp_tag_q;

endmodule : alu_cmd_sequencer
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- FIFO_DEPTH, default 4: command FIFO entries; power of 2, >=2.
- TIMEOUT, default 15: max WAIT cycles before abort; only used with the timeout feature.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO not full.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B / register index.
- cmd_op  in  3  opcode.
- alu_a  out  8  registered operand to ALU.
- alu_b  out  8  registered operand to ALU.
- alu_op  out  3  registered opcode to ALU.
- alu_start  out  1  one-cycle start pulse.
- alu_done  in  1  ALU idle/complete; high when idle.
- alu_result  in  16  ALU result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accepted.
- rsp_result  out  16  captured result.
- rsp_op  out  3  opcode of the response.
- rsp_tag  out  8  issue sequence number.
- rsp_error  out  1  timeout abort flag.

Function
REQ-003 A command SHALL be pushed on a clk edge where cmd_valid && cmd_ready; cmd_ready SHALL equal !full, derived from registered occupancy only.
REQ-004 When the FIFO is full and a pop occurs in the same cycle, the push SHALL NOT occur, because cmd_ready is already low; when the FIFO is empty, a push followed by a pop SHALL take at least 2 cycles.
REQ-005 The FSM states SHALL be IDLE, ISSUE, ARM, WAIT and RESP.
REQ-006 IDLE->ISSUE SHALL occur when the FIFO is non-empty and alu_done=1; on that edge the FIFO head SHALL be popped into alu_a, alu_b and alu_op.
REQ-007 In ISSUE, alu_start SHALL be 1 for exactly one cycle; ISSUE->ARM SHALL be unconditional.
REQ-008 ARM SHALL last one cycle, during which alu_done is ignored; ARM->WAIT SHALL be unconditional.
REQ-009 In WAIT, on the first cycle with alu_done=1, the state SHALL move to RESP and the registers SHALL be loaded as rsp_result<=alu_result, rsp_op<=alu_op, rsp_tag<=tag, rsp_error<=0.
REQ-010 alu_a, alu_b and alu_op SHALL hold stable from ISSUE until RESP is entered.
REQ-011 In RESP, rsp_valid SHALL be 1 and all rsp_* outputs SHALL be stable until rsp_ready=1, then RESP->IDLE; rsp_valid SHALL never be combinationally dependent on rsp_ready.
REQ-012 The 8-bit tag SHALL increment on each ISSUE and wrap from 255 to 0.
REQ-013 Minimum command-to-command throughput SHALL be 5 cycles (IDLE, ISSUE, ARM, WAIT, RESP) with rsp_ready held at 1.
REQ-014 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with an extra count bit so that full and empty are unambiguous.

Reset
REQ-015 Asserting reset_n low SHALL asynchronously force state=IDLE, an empty FIFO, tag=0, and cmd_ready=0 while reset is asserted.
REQ-016 During reset, alu_a, alu_b and alu_op SHALL be 0, alu_start=0, rsp_valid=0, and rsp_result, rsp_op, rsp_tag and rsp_error SHALL all be 0.
REQ-017 Reset asserted mid-operation in any state SHALL discard the in-flight command and all queued commands, with no response emitted.

Configuration
REQ-018 With macro ALU_CMD_SEQUENCER_TIMEOUT_EN defined, a WAIT cycle counter SHALL run; if TIMEOUT cycles elapse without alu_done, the FSM SHALL enter RESP with rsp_error=1 and rsp_result=0.
REQ-019 Without ALU_CMD_SEQUENCER_TIMEOUT_EN, no counter SHALL exist, rsp_error SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Structure
REQ-020 Package alu_seq_pkg SHALL hold:
- the opcode enum: NOP=0, ADD=1, AND=4, WR=5, RD=6;
- the state enum;
- localparams for DATA_W=8, RES_W=16, OP_W=3 and TAG_W=8.
REQ-021 The command FIFO SHALL be the sub-module alu_seq_fifo, a single-clock synchronous FIFO parameterised by width and depth; the FSM and the timeout logic SHALL reside in the top-level module.

Verification
REQ-022 The bench SHALL cover:
- ADD A=8'h12, B=8'h34, ALU model completes after 2 cycles -> one rsp with result 16'h0046, op=1, tag=0, error=0.
- 5 commands pushed back-to-back with FIFO_DEPTH=4 and the ALU stalled -> cmd_ready falls after the 4th accept; all 5 responses return in order with tags 0..4.
- rsp_ready held 0 for 10 cycles in RESP -> rsp_* stable; no new alu_start until the response is accepted.
- WR A=8'hAA, B=2, then RD B=2 -> RD response result 16'h00AA.
- Timeout build with TIMEOUT=15 and alu_done held 0 -> rsp_error=1, result 0 after 15 WAIT cycles; non-timeout build -> no response.
- reset_n pulsed low in WAIT with 2 commands queued -> all outputs reset; no responses after release; the next command gets tag=0.
